// File: rtl/battleship_pkg.sv
//------------------------------------------------------------------------------
// Module   : battleship_pkg
// Brief    : Shared key codes, controller state encoding and player type.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package battleship_pkg;

  localparam logic [3:0] KEY_A     = 4'hA;
  localparam logic [3:0] KEY_B     = 4'hB;
  localparam logic [3:0] KEY_C     = 4'hC;
  localparam logic [3:0] KEY_D     = 4'hD;
  localparam logic [3:0] KEY_ENTER = 4'hE;
  localparam logic [3:0] KEY_CLEAR = 4'hF;

  typedef enum logic [2:0] {
    ST_WAIT_ROW   = 3'd0,
    ST_WAIT_COL   = 3'd1,
    ST_WAIT_ENTER = 3'd2,
    ST_FIRE       = 3'd3,
    ST_SHOW       = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

  typedef logic player_t;

endpackage

`default_nettype wire

// File: rtl/shot_entry_controller.sv
//------------------------------------------------------------------------------
// Module   : shot_entry_controller
// Brief    : Two-player keypad shot entry, req/ack shot issue, result hold and
//            turn hand-over with sticky game over.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shot_entry_controller
  import battleship_pkg::*;
#(
  parameter  int GRID        = 8,
  parameter  int SHOW_CYCLES = 100_000_000,
  localparam int CW          = $clog2(GRID)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    key_code,
  input  logic          key_valid,
  output logic          shot_req,
  output logic          shot_player,
  output logic [CW-1:0] shot_row,
  output logic [CW-1:0] shot_col,
  input  logic          shot_ack,
  input  logic          hit,
  input  logic          win,
  output logic          player,
  output logic          row_vld,
  output logic          col_vld,
  output logic          last_hit,
  output logic          show,
  output logic          err,
  output logic          game_over,
  output logic          winner
);

  localparam int            CNTW     = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(SHOW_CYCLES - 1);

  state_t          r_state,    w_state_nxt;
  player_t         r_player,   w_player_nxt;
  logic [CW-1:0]   r_row,      w_row_nxt;
  logic [CW-1:0]   r_col,      w_col_nxt;
  logic            r_row_vld,  w_row_vld_nxt;
  logic            r_col_vld,  w_col_vld_nxt;
  logic            r_last_hit, w_last_hit_nxt;
  logic            r_err,      w_err_nxt;
  player_t         r_winner,   w_winner_nxt;
  logic [CNTW-1:0] r_cnt,      w_cnt_nxt;
  logic            r_shot_req;
  logic            r_show;
  logic            r_game_over;
  logic            w_is_digit;

  // A-D exceed 9 and so are never digits, whatever GRID is.
  assign w_is_digit = (key_code <= 4'h9) && (key_code < 4'(GRID));

  always_comb begin
    w_state_nxt    = r_state;
    w_player_nxt   = r_player;
    w_row_nxt      = r_row;
    w_col_nxt      = r_col;
    w_row_vld_nxt  = r_row_vld;
    w_col_vld_nxt  = r_col_vld;
    w_last_hit_nxt = r_last_hit;
    w_err_nxt      = 1'b0;
    w_winner_nxt   = r_winner;
    w_cnt_nxt      = r_cnt;
    case (r_state)
      ST_WAIT_ROW: begin
        if (key_valid) begin
          if (w_is_digit) begin
            w_row_nxt     = key_code[CW-1:0];
            w_row_vld_nxt = 1'b1;
            w_state_nxt   = ST_WAIT_COL;
          end else if (key_code != KEY_CLEAR) begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_WAIT_COL: begin
        if (key_valid) begin
          if (w_is_digit) begin
            w_col_nxt     = key_code[CW-1:0];
            w_col_vld_nxt = 1'b1;
            w_state_nxt   = ST_WAIT_ENTER;
          end else if (key_code == KEY_CLEAR) begin
            w_row_vld_nxt = 1'b0;
            w_col_vld_nxt = 1'b0;
            w_state_nxt   = ST_WAIT_ROW;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_WAIT_ENTER: begin
        if (key_valid) begin
          if (key_code == KEY_ENTER) begin
            w_state_nxt = ST_FIRE;
          end else if (key_code == KEY_CLEAR) begin
            w_row_vld_nxt = 1'b0;
            w_col_vld_nxt = 1'b0;
            w_state_nxt   = ST_WAIT_ROW;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_FIRE: begin
        if (shot_ack) begin
          w_last_hit_nxt = hit;
          w_cnt_nxt      = '0;
          if (win) begin
            w_winner_nxt = r_player;
            w_state_nxt  = ST_DONE;
          end else begin
            w_state_nxt  = ST_SHOW;
          end
        end
      end
      ST_SHOW: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt     = '0;
          w_player_nxt  = ~r_player;
          w_row_vld_nxt = 1'b0;
          w_col_vld_nxt = 1'b0;
          w_state_nxt   = ST_WAIT_ROW;
        end else begin
          w_cnt_nxt = r_cnt + CNTW'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_DONE;
      end
      default: begin
        w_state_nxt = ST_WAIT_ROW;
      end
    endcase
  end

  // Status outputs are decoded from the next state so they stay registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_WAIT_ROW;
      r_player    <= 1'b0;
      r_row       <= '0;
      r_col       <= '0;
      r_row_vld   <= 1'b0;
      r_col_vld   <= 1'b0;
      r_last_hit  <= 1'b0;
      r_err       <= 1'b0;
      r_winner    <= 1'b0;
      r_cnt       <= '0;
      r_shot_req  <= 1'b0;
      r_show      <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_player    <= w_player_nxt;
      r_row       <= w_row_nxt;
      r_col       <= w_col_nxt;
      r_row_vld   <= w_row_vld_nxt;
      r_col_vld   <= w_col_vld_nxt;
      r_last_hit  <= w_last_hit_nxt;
      r_err       <= w_err_nxt;
      r_winner    <= w_winner_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shot_req  <= (w_state_nxt == ST_FIRE);
      r_show      <= (w_state_nxt == ST_SHOW);
      r_game_over <= (w_state_nxt == ST_DONE);
    end
  end

  assign shot_req    = r_shot_req;
  assign shot_player = r_player;
  assign shot_row    = r_row;
  assign shot_col    = r_col;
  assign player      = r_player;
  assign row_vld     = r_row_vld;
  assign col_vld     = r_col_vld;
  assign last_hit    = r_last_hit;
  assign show        = r_show;
  assign err         = r_err;
  assign game_over   = r_game_over;
  assign winner      = r_winner;

endmodule

`default_nettype wire

// File: tb/tb_shot_entry_controller.sv
//------------------------------------------------------------------------------
// Module   : tb_shot_entry_controller
// Brief    : Directed self-checking bench for shot_entry_controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_shot_entry_controller;

  localparam int GRID        = 8;
  localparam int SHOW_CYCLES = 4;
  localparam int CW          = $clog2(GRID);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    key_code;
  logic          key_valid;
  logic          shot_req;
  logic          shot_player;
  logic [CW-1:0] shot_row;
  logic [CW-1:0] shot_col;
  logic          shot_ack;
  logic          hit;
  logic          win;
  logic          player;
  logic          row_vld;
  logic          col_vld;
  logic          last_hit;
  logic          show;
  logic          err;
  logic          game_over;
  logic          winner;

  int n_tests = 0;
  int n_fail  = 0;

  shot_entry_controller #(.GRID(GRID), .SHOW_CYCLES(SHOW_CYCLES)) u_dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_valid(key_valid),
    .shot_req(shot_req), .shot_player(shot_player), .shot_row(shot_row),
    .shot_col(shot_col), .shot_ack(shot_ack), .hit(hit), .win(win),
    .player(player), .row_vld(row_vld), .col_vld(col_vld),
    .last_hit(last_hit), .show(show), .err(err), .game_over(game_over),
    .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    key_code  = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic wait_show_end(output int n);
    n = 0;
    while (show === 1'b1 && n < 20) begin
      n++;
      tick();
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({shot_req, shot_player, shot_row, shot_col, player, row_vld,
                col_vld, last_hit, show, err, game_over, winner});
  endfunction

  initial begin
    int n;
    rst_n = 1'b0; key_code = 4'h0; key_valid = 1'b0;
    shot_ack = 1'b0; hit = 1'b0; win = 1'b0;
    tick(); tick();
    chk("reset_outputs", all_outs(), 32'd0);
    rst_n = 1'b1;

    // Player 0: 3,5,E, ack+hit in the second request cycle
    press(4'h3);
    chk("p0_row_vld", 32'(row_vld), 32'd1);
    chk("p0_row", 32'(shot_row), 32'd3);
    press(4'h5);
    chk("p0_col", 32'({col_vld, shot_col}), 32'h0D);
    press(4'hE);
    chk("p0_req_first", 32'({shot_req, shot_player, shot_row, shot_col}), 32'({1'b1, 1'b0, 3'd3, 3'd5}));
    tick();
    chk("p0_req_second", 32'(shot_req), 32'd1);
    shot_ack = 1'b1; hit = 1'b1;
    tick();
    shot_ack = 1'b0; hit = 1'b0;
    chk("p0_after_ack", 32'({shot_req, last_hit, show}), 32'b011);
    wait_show_end(n);
    chk("p0_show_len", 32'(n), 32'd4);
    chk("p0_handover", 32'({player, row_vld, col_vld}), 32'b100);

    // Player 1: back-to-back rejected keys 9 then A
    key_code = 4'h9; key_valid = 1'b1;
    tick();
    chk("err_9", 32'({err, row_vld}), 32'b10);
    key_code = 4'hA;
    tick();
    chk("err_A", 32'({err, row_vld}), 32'b10);
    key_valid = 1'b0;
    tick();
    chk("err_single", 32'(err), 32'd0);

    // Player 1: 2, F, 4, 1, E then zero-wait ack with miss
    press(4'h2);
    press(4'hF);
    chk("clear_col_state", 32'({row_vld, col_vld, err}), 32'b000);
    press(4'h4);
    press(4'h1);
    press(4'hE);
    chk("p1_req", 32'({shot_req, shot_player, shot_row, shot_col}), 32'({1'b1, 1'b1, 3'd4, 3'd1}));
    shot_ack = 1'b1; hit = 1'b0;
    tick();
    shot_ack = 1'b0;
    chk("p1_zero_wait", 32'({shot_req, last_hit, show}), 32'b001);
    wait_show_end(n);
    chk("p1_show_len", 32'(n), 32'd4);
    chk("p1_handover", 32'(player), 32'd0);

    // Player 0: 2, 6, 7 rejected in WAIT_ENTER; keys ignored in FIRE/SHOW
    press(4'h2);
    press(4'h6);
    press(4'h7);
    chk("enter_digit_err", 32'({err, col_vld, shot_col}), 32'({1'b1, 1'b1, 3'd6}));
    press(4'hE);
    press(4'h5);
    chk("fire_key_ignored", 32'({err, shot_req, shot_row, shot_col}), 32'({1'b0, 1'b1, 3'd2, 3'd6}));
    shot_ack = 1'b1; hit = 1'b1;
    tick();
    shot_ack = 1'b0; hit = 1'b0;
    press(4'hB);
    chk("show_key_ignored", 32'({err, show, row_vld, shot_row}), 32'({1'b0, 1'b1, 1'b1, 3'd2}));
    wait_show_end(n);
    chk("p0b_show_rest", 32'(n), 32'd3);
    chk("p0b_handover", 32'(player), 32'd1);

    // Player 1 wins
    press(4'h7);
    press(4'h7);
    press(4'hE);
    shot_ack = 1'b1; hit = 1'b1; win = 1'b1;
    tick();
    shot_ack = 1'b0; hit = 1'b0; win = 1'b0;
    chk("win_state", 32'({game_over, winner, show, shot_req, last_hit}), 32'b11001);
    press(4'h3);
    chk("done_key", 32'({err, game_over, row_vld, shot_row}), 32'({1'b0, 1'b1, 1'b1, 3'd7}));
    shot_ack = 1'b1; hit = 1'b0; win = 1'b0;
    tick();
    shot_ack = 1'b0;
    tick();
    chk("done_ack", 32'({game_over, winner, last_hit, show, shot_req}), 32'b11100);

    // Reset mid-handshake
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    press(4'h1);
    press(4'h1);
    press(4'hE);
    chk("pre_abort_req", 32'(shot_req), 32'd1);
    rst_n = 1'b0; shot_ack = 1'b1;
    tick();
    shot_ack = 1'b0;
    chk("abort_outputs", all_outs(), 32'd0);
    rst_n = 1'b1;
    press(4'h3);
    chk("abort_wait_row", 32'({row_vld, shot_row, err}), 32'({1'b1, 3'd3, 1'b0}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
